// File: rtl/recovery_retry_sequencer.sv
// Checkpoint/rollback sequencer: freeze, drain, restore the checkpoint PC, and retry under a bounded budget; halts on critical faults.
// Outputs are registered from next state, so freeze follows a fault by one cycle. The restore pulse arrives DRAIN_CYCLES+1 cycles after the fault.
module recovery_retry_sequencer #(
   parameter int unsigned MAX_RETRIES  = 3,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned RETRY_WINDOW = 16,
   parameter logic [31:0] RESET_PC     = 32'h0,
   localparam int unsigned RCW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1,
   localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1,
   localparam int unsigned WCW = (RETRY_WINDOW > 1) ? $clog2(RETRY_WINDOW) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           minor_fault,
   input  logic           critical_fault,
   input  logic           commit_valid,
   input  logic [31:0]    commit_pc,
   output logic           freeze,
   output logic           flush,
   output logic           pc_restore_valid,
   output logic [31:0]    pc_restore,
   output logic           retry_active,
   output logic           halted,
   output logic [RCW-1:0] retry_count,
   output logic [15:0]    fault_count,
   output logic [2:0]     fsm_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DRAIN   = 3'd1,
      RESTORE = 3'd2,
      RETRY   = 3'd3,
      HALT    = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic [WCW-1:0] win_q, win_d;
   logic [RCW-1:0] rc_q, rc_d;
   logic [31:0]    ckpt_q, ckpt_d;
   logic [15:0]    fc_q, fc_d;
   logic           fc_inc;
   logic           fail;
   logic           freeze_q, flush_q, pcrv_q, retry_active_q, halted_q;

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      win_d   = win_q;
      rc_d    = rc_q;
      ckpt_d  = ckpt_q;
      fc_inc  = 1'b0;
      fail    = 1'b0;
      case (state_q)
         IDLE: begin
            if (critical_fault) begin
               state_d = HALT;
               fc_inc  = 1'b1;
            end else if (minor_fault) begin
               fc_inc = 1'b1;
               if (MAX_RETRIES == 0) begin
                  state_d = HALT;
               end else begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end else if (commit_valid) begin
               ckpt_d = commit_pc;
            end
         end
         DRAIN: begin
            if (critical_fault) begin
               state_d = HALT;
               fc_inc  = 1'b1;
            end else if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
               state_d = RESTORE;
            end else begin
               drain_d = drain_q + DCW'(1);
            end
         end
         RESTORE: begin
            rc_d  = rc_q + RCW'(1);
            win_d = '0;
            if (critical_fault) begin
               state_d = HALT;
               fc_inc  = 1'b1;
            end else begin
               state_d = RETRY;
            end
         end
         RETRY: begin
            if (critical_fault) begin
               state_d = HALT;
               fc_inc  = 1'b1;
            end else if (minor_fault) begin
               fc_inc = 1'b1;
               fail   = 1'b1;
            end else if (commit_valid && (commit_pc == ckpt_q)) begin
               state_d = IDLE;
               rc_d    = '0;
            end else if (win_q == WCW'(RETRY_WINDOW - 1)) begin
               fail = 1'b1;
            end else begin
               win_d = win_q + WCW'(1);
            end
            // A failed attempt either spends another retry or exhausts the budget.
            if (fail) begin
               if (rc_q == RCW'(MAX_RETRIES)) begin
                  state_d = HALT;
               end else begin
                  state_d = DRAIN;
                  drain_d = '0;
               end
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      fc_d = (fc_inc && (fc_q != 16'hFFFF)) ? fc_q + 16'd1 : fc_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         drain_q        <= '0;
         win_q          <= '0;
         rc_q           <= '0;
         ckpt_q         <= RESET_PC;
         fc_q           <= '0;
         freeze_q       <= 1'b0;
         flush_q        <= 1'b0;
         pcrv_q         <= 1'b0;
         retry_active_q <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         drain_q        <= drain_d;
         win_q          <= win_d;
         rc_q           <= rc_d;
         ckpt_q         <= ckpt_d;
         fc_q           <= fc_d;
         freeze_q       <= (state_d == DRAIN) || (state_d == RESTORE) || (state_d == HALT);
         flush_q        <= (state_d == DRAIN) && (state_q != DRAIN);
         pcrv_q         <= (state_d == RESTORE);
         retry_active_q <= (state_d == RETRY);
         halted_q       <= (state_d == HALT);
      end
   end

   assign freeze           = freeze_q;
   assign flush            = flush_q;
   assign pc_restore_valid = pcrv_q;
   assign pc_restore       = ckpt_q;
   assign retry_active     = retry_active_q;
   assign halted           = halted_q;
   assign retry_count      = rc_q;
   assign fault_count      = fc_q;
   assign fsm_state        = state_q;

endmodule

// File: tb/tb_recovery_retry_sequencer.sv
// Randomized and directed bench for recovery_retry_sequencer against an episode-level reference model.
module tb_recovery_retry_sequencer;

   localparam int MAXR = 3;
   localparam int DRN  = 2;
   localparam int RW   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        minor_fault, critical_fault, commit_valid;
   logic [31:0] commit_pc;
   logic        freeze, flush, pc_restore_valid, retry_active, halted;
   logic [31:0] pc_restore;
   logic [1:0]  retry_count;
   logic [15:0] fault_count;
   logic [2:0]  fsm_state;

   int checks = 0;
   int errors = 0;

   recovery_retry_sequencer #(
      .MAX_RETRIES(MAXR), .DRAIN_CYCLES(DRN), .RETRY_WINDOW(RW), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .reset(reset), .minor_fault(minor_fault), .critical_fault(critical_fault),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .freeze(freeze), .flush(flush),
      .pc_restore_valid(pc_restore_valid), .pc_restore(pc_restore), .retry_active(retry_active),
      .halted(halted), .retry_count(retry_count), .fault_count(fault_count), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   // Reference model: an episode is a drain countdown, a restore beat, then a retry countdown.
   bit          m_halt, m_restore, m_flush;
   int          m_drain_left, m_window_left, m_attempts;
   int          m_fc;
   logic [31:0] m_ckpt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_halt = 0; m_restore = 0; m_flush = 0;
      m_drain_left = 0; m_window_left = 0; m_attempts = 0;
      m_fc = 0; m_ckpt = 32'h0;
   endfunction

   function automatic void count_fault();
      if (m_fc < 65535) m_fc++;
   endfunction

   function automatic void start_drain();
      m_drain_left = DRN;
      m_flush = 1;
   endfunction

   function automatic void model_step(input logic rst_n, input logic mf, input logic cf,
                                      input logic cv, input logic [31:0] pc);
      bit failed;
      failed = 0;
      if (!rst_n) begin
         model_reset();
      end else begin
         m_flush = 0;
         if (m_halt) begin
         end else if (m_drain_left > 0) begin
            if (cf) begin
               count_fault(); m_halt = 1; m_drain_left = 0;
            end else begin
               m_drain_left--;
               if (m_drain_left == 0) m_restore = 1;
            end
         end else if (m_restore) begin
            m_restore = 0;
            m_attempts++;
            if (cf) begin
               count_fault(); m_halt = 1;
            end else begin
               m_window_left = RW;
            end
         end else if (m_window_left > 0) begin
            if (cf) begin
               count_fault(); m_halt = 1; m_window_left = 0;
            end else if (mf) begin
               count_fault(); failed = 1;
            end else if (cv && pc == m_ckpt) begin
               m_window_left = 0; m_attempts = 0;
            end else begin
               m_window_left--;
               if (m_window_left == 0) failed = 1;
            end
            if (failed) begin
               m_window_left = 0;
               if (m_attempts >= MAXR) m_halt = 1;
               else start_drain();
            end
         end else begin
            if (cf) begin
               count_fault(); m_halt = 1;
            end else if (mf) begin
               count_fault();
               if (MAXR == 0) m_halt = 1;
               else start_drain();
            end else if (cv) begin
               m_ckpt = pc;
            end
         end
      end
   endfunction

   task automatic compare_all();
      int exp_state;
      exp_state = m_halt ? 4 : (m_drain_left > 0) ? 1 : m_restore ? 2 : (m_window_left > 0) ? 3 : 0;
      check_eq("fsm_state", 32'(fsm_state), 32'(exp_state));
      check_eq("freeze", 32'(freeze), 32'(m_halt || m_drain_left > 0 || m_restore));
      check_eq("flush", 32'(flush), 32'(m_flush));
      check_eq("pc_restore_valid", 32'(pc_restore_valid), 32'(m_restore));
      check_eq("retry_active", 32'(retry_active), 32'(m_window_left > 0));
      check_eq("halted", 32'(halted), 32'(m_halt));
      check_eq("pc_restore", pc_restore, m_ckpt);
      check_eq("retry_count", 32'(retry_count), 32'(m_attempts));
      check_eq("fault_count", 32'(fault_count), 32'(m_fc));
   endtask

   task automatic step(input logic rst_n, input logic mf, input logic cf,
                       input logic cv, input logic [31:0] pc);
      reset = rst_n; minor_fault = mf; critical_fault = cf; commit_valid = cv; commit_pc = pc;
      @(posedge clk);
      model_step(rst_n, mf, cf, cv, pc);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0);
   endtask

   initial begin
      int pulses;
      logic mf, cf, cv, rst_n;
      logic [31:0] pc;
      model_reset();
      reset = 0; minor_fault = 0; critical_fault = 0; commit_valid = 0; commit_pc = 0;

      // Clean recovery: checkpoint 0x100, minor fault, matching commit in RETRY.
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      check_eq("rst_fsm", 32'(fsm_state), 32'd0);
      check_eq("rst_pc", pc_restore, 32'h0);
      step(1, 0, 0, 1, 32'h100);
      step(1, 1, 0, 0, 0);
      check_eq("t1_flush", 32'(flush), 32'd1);
      check_eq("t1_freeze", 32'(freeze), 32'd1);
      idle(2);
      check_eq("t1_pcrv", 32'(pc_restore_valid), 32'd1);
      check_eq("t1_pc", pc_restore, 32'h100);
      idle(1);
      check_eq("t1_retry_active", 32'(retry_active), 32'd1);
      check_eq("t1_rc_in_retry", 32'(retry_count), 32'd1);
      step(1, 0, 0, 1, 32'h100);
      check_eq("t1_state", 32'(fsm_state), 32'd0);
      check_eq("t1_rc", 32'(retry_count), 32'd0);
      check_eq("t1_fc", 32'(fault_count), 32'd1);

      // Minor fault in every retry exhausts the budget.
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         step(1, (m_window_left > 0), 0, 0, 0);
         if (pc_restore_valid) pulses++;
      end
      check_eq("t2_pulses", 32'(pulses), 32'd3);
      check_eq("t2_halted", 32'(halted), 32'd1);
      check_eq("t2_fc", 32'(fault_count), 32'd4);

      // Critical fault with a simultaneous commit keeps the old checkpoint.
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h100);
      step(1, 0, 1, 1, 32'h200);
      check_eq("t3_halted", 32'(halted), 32'd1);
      check_eq("t3_pc", pc_restore, 32'h100);
      check_eq("t3_fc", 32'(fault_count), 32'd1);

      // Window expiry with no commits, three times, then halt.
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      idle(3 + RW);
      check_eq("t4_first_expiry", 32'(fsm_state), 32'd1);
      idle(60);
      check_eq("t4_halted", 32'(halted), 32'd1);
      check_eq("t4_rc", 32'(retry_count), 32'd3);
      check_eq("t4_fc", 32'(fault_count), 32'd1);

      // Minor in DRAIN is ignored; critical in RESTORE halts.
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check_eq("t5_fc_drain", 32'(fault_count), 32'd1);
      idle(1);
      check_eq("t5_pcrv", 32'(pc_restore_valid), 32'd1);
      step(1, 0, 1, 0, 0);
      check_eq("t5_halted", 32'(halted), 32'd1);
      check_eq("t5_fc", 32'(fault_count), 32'd2);

      // Reset from RETRY and from HALT.
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 32'h44);
      step(1, 1, 0, 0, 0);
      idle(3);
      check_eq("t6_in_retry", 32'(retry_active), 32'd1);
      step(0, 0, 0, 0, 0);
      check_eq("t6_rst_state", 32'(fsm_state), 32'd0);
      check_eq("t6_rst_pc", pc_restore, 32'h0);
      check_eq("t6_rst_freeze", 32'(freeze), 32'd0);
      check_eq("t6_rst_fc", 32'(fault_count), 32'd0);
      step(1, 0, 1, 0, 0);
      check_eq("t6_halt", 32'(halted), 32'd1);
      step(0, 0, 0, 0, 0);
      check_eq("t6_rst_halted", 32'(halted), 32'd0);
      check_eq("t6_rst_rc", 32'(retry_count), 32'd0);

      // Random traffic with occasional resets to escape HALT.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         mf    = ($urandom_range(0, 11) == 0);
         cf    = ($urandom_range(0, 149) == 0);
         cv    = $urandom_range(0, 1) == 1;
         pc    = ($urandom_range(0, 1) == 1) ? m_ckpt : ($urandom() & 32'hFFFF_FFFC);
         step(rst_n, mf, cf, cv, pc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
